// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: autonomous command sequencer for the spi_core register port.
// Programs divider/slave-select, sends a header word, then reads N data words onto a stream.
module spi_xfer_seq #(
  parameter int unsigned LenW     = 8,
  parameter logic [15:0] ClkDiv   = 16'd1,
  parameter logic [7:0]  SsMask   = 8'h01,
  parameter logic [31:0] CtrlVal  = 32'h0000_2020,
  parameter int unsigned GoBit    = 8,
  parameter logic [7:0]  CtrlAddr = 8'h10,
  parameter logic [7:0]  DivAddr  = 8'h14,
  parameter logic [7:0]  SsAddr   = 8'h18,
  parameter logic [7:0]  Tx0Addr  = 8'h00,
  parameter logic [7:0]  Rx0Addr  = 8'h00,
  parameter int unsigned TimeoutW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [7:0]      req_cmd_i,
  input  logic [23:0]     req_addr_i,
  input  logic [LenW-1:0] req_words_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_data_o,
  output logic            rsp_err_o,
  output logic            busy_o,
  output logic            reg_we_o,
  output logic            reg_re_o,
  output logic [7:0]      reg_addr_o,
  output logic [31:0]     reg_wdata_o,
  output logic [3:0]      reg_be_o,
  input  logic [31:0]     reg_rdata_i,
  input  logic            reg_err_i
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DIV     = 4'd1,
    ST_SS_ON   = 4'd2,
    ST_TX_WR   = 4'd3,
    ST_GO_WR   = 4'd4,
    ST_POLL    = 4'd5,
    ST_RX_RD   = 4'd6,
    ST_RSP     = 4'd7,
    ST_SS_OFF  = 4'd8,
    ST_ERR_SS  = 4'd9,
    ST_ERR_RSP = 4'd10
  } state_e;

  localparam logic [31:0]         CtrlGo  = CtrlVal | (32'h0000_0001 << GoBit);
  localparam logic [TimeoutW-1:0] TmoLast = {{(TimeoutW-1){1'b1}}, 1'b0};
  localparam logic [TimeoutW-1:0] TmoOne  = {{(TimeoutW-1){1'b0}}, 1'b1};
  localparam logic [LenW-1:0]     WordOne = {{(LenW-1){1'b0}}, 1'b1};

  state_e              state_r, state_s;
  logic                hdr_phase_r, hdr_phase_s;
  logic [LenW-1:0]     words_left_r;
  logic [31:0]         header_r;
  logic [TimeoutW-1:0] tmo_cnt_r;

  logic                we_d_s, re_d_s, ready_d_s, valid_d_s, err_d_s, busy_d_s;
  logic [7:0]          addr_d_s;
  logic [31:0]         wdata_d_s;

  logic                accept_s, err_hit_s, busy_bit_s, tmo_sat_s, rsp_fire_s;
  logic [LenW-1:0]     words_dec_s;

  assign accept_s    = (state_r == ST_IDLE) && req_valid_i && req_ready_o;
  // An error on the closing SS write of the error path itself is ignored.
  assign err_hit_s   = (reg_we_o || reg_re_o) && reg_err_i && (state_r != ST_ERR_SS);
  assign busy_bit_s  = reg_rdata_i[GoBit];
  assign tmo_sat_s   = (tmo_cnt_r == TmoLast);
  assign rsp_fire_s  = rsp_valid_o && rsp_ready_i;
  assign words_dec_s = words_left_r - WordOne;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      hdr_phase_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      hdr_phase_r <= hdr_phase_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s     = state_r;
    hdr_phase_s = hdr_phase_r;
    if (err_hit_s) begin
      state_s = ST_ERR_SS;
    end else begin
      case (state_r)
        ST_IDLE:   state_s = accept_s ? ST_DIV : ST_IDLE;
        ST_DIV:    state_s = ST_SS_ON;
        ST_SS_ON: begin
          state_s     = ST_TX_WR;
          hdr_phase_s = 1'b1;
        end
        ST_TX_WR:  state_s = ST_GO_WR;
        ST_GO_WR:  state_s = ST_POLL;
        ST_POLL: begin
          if (!busy_bit_s) begin
            if (hdr_phase_r) begin
              hdr_phase_s = 1'b0;
              state_s     = (words_left_r != {LenW{1'b0}}) ? ST_TX_WR : ST_SS_OFF;
            end else begin
              state_s = ST_RX_RD;
            end
          end else if (tmo_sat_s) begin
            state_s = ST_ERR_SS;
          end else begin
            state_s = ST_POLL;
          end
        end
        ST_RX_RD:  state_s = ST_RSP;
        ST_RSP: begin
          if (rsp_fire_s) begin
            state_s = (words_dec_s != {LenW{1'b0}}) ? ST_TX_WR : ST_SS_OFF;
          end else begin
            state_s = ST_RSP;
          end
        end
        ST_SS_OFF:  state_s = ST_IDLE;
        ST_ERR_SS:  state_s = ST_ERR_RSP;
        ST_ERR_RSP: state_s = rsp_fire_s ? ST_IDLE : ST_ERR_RSP;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    we_d_s    = 1'b0;
    re_d_s    = 1'b0;
    addr_d_s  = 8'h00;
    wdata_d_s = 32'h0000_0000;
    ready_d_s = 1'b0;
    valid_d_s = 1'b0;
    err_d_s   = 1'b0;
    busy_d_s  = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE:   ready_d_s = 1'b1;
      ST_DIV: begin
        we_d_s    = 1'b1;
        addr_d_s  = DivAddr;
        wdata_d_s = {16'h0000, ClkDiv};
      end
      ST_SS_ON: begin
        we_d_s    = 1'b1;
        addr_d_s  = SsAddr;
        wdata_d_s = {24'h00_0000, SsMask};
      end
      ST_TX_WR: begin
        we_d_s    = 1'b1;
        addr_d_s  = Tx0Addr;
        wdata_d_s = hdr_phase_s ? header_r : 32'h0000_0000;
      end
      ST_GO_WR: begin
        we_d_s    = 1'b1;
        addr_d_s  = CtrlAddr;
        wdata_d_s = CtrlGo;
      end
      ST_POLL: begin
        re_d_s   = 1'b1;
        addr_d_s = CtrlAddr;
      end
      ST_RX_RD: begin
        re_d_s   = 1'b1;
        addr_d_s = Rx0Addr;
      end
      ST_RSP:    valid_d_s = 1'b1;
      ST_SS_OFF, ST_ERR_SS: begin
        we_d_s    = 1'b1;
        addr_d_s  = SsAddr;
        wdata_d_s = 32'h0000_0000;
      end
      ST_ERR_RSP: begin
        valid_d_s = 1'b1;
        err_d_s   = 1'b1;
      end
      default: begin
        we_d_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      reg_addr_o  <= 8'h00;
      reg_wdata_o <= 32'h0000_0000;
      reg_be_o    <= 4'h0;
      rsp_data_o  <= 32'h0000_0000;
    end else begin
      req_ready_o <= ready_d_s;
      rsp_valid_o <= valid_d_s;
      rsp_err_o   <= err_d_s;
      busy_o      <= busy_d_s;
      reg_we_o    <= we_d_s;
      reg_re_o    <= re_d_s;
      reg_addr_o  <= addr_d_s;
      reg_wdata_o <= wdata_d_s;
      reg_be_o    <= (we_d_s || re_d_s) ? 4'hF : 4'h0;
      if (state_r == ST_RX_RD) begin
        rsp_data_o <= reg_rdata_i;
      end else if (state_s == ST_ERR_RSP) begin
        rsp_data_o <= 32'h0000_0000;
      end else begin
        rsp_data_o <= rsp_data_o;
      end
    end
  end

  // Request latch, word counter and busy-poll timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      header_r     <= 32'h0000_0000;
      words_left_r <= {LenW{1'b0}};
      tmo_cnt_r    <= {TimeoutW{1'b0}};
    end else begin
      if (accept_s) begin
        header_r     <= {req_cmd_i, req_addr_i};
        words_left_r <= req_words_i;
      end else if (state_r == ST_RSP && rsp_fire_s) begin
        words_left_r <= words_dec_s;
      end else begin
        words_left_r <= words_left_r;
      end
      if (state_r == ST_GO_WR) begin
        tmo_cnt_r <= {TimeoutW{1'b0}};
      end else if (state_r == ST_POLL && busy_bit_s) begin
        tmo_cnt_r <= tmo_cnt_r + TmoOne;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: a small spi_core register model answers the strobes, and each
// transaction's strobe list and response beats are compared with a list built from the rules.
module tb_spi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic [7:0]  req_cmd_i;
  logic [23:0] req_addr_i;
  logic [7:0]  req_words_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [31:0] rsp_data_o;
  logic        reg_we_o, reg_re_o, reg_err_i;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o, reg_rdata_i;
  logic [3:0]  reg_be_o;

  always #5 clk = ~clk;

  spi_xfer_seq #(.TimeoutW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_words_i(req_words_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
    .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [40:0] strobe_q[$];  // {we, addr, wdata} as observed
  logic [32:0] rsp_q[$];     // {err, data} per accepted beat
  logic [31:0] rx_q[$];      // words the core model returns from RX0
  logic [31:0] rx_plan[$];   // optional fixed RX words for the next transaction
  int          busy_cfg, busy_left;
  bit          busy_inf, err_arm;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] wr(input logic [7:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [40:0] rd(input logic [7:0] a);
    return {1'b0, a, 32'h0000_0000};
  endfunction

  // One clock: record a pending handshake, advance, log the new strobe and answer it.
  task automatic cyc();
    if (rsp_valid_o && rsp_ready_i) rsp_q.push_back({rsp_err_o, rsp_data_o});
    @(posedge clk);
    #1;
    reg_rdata_i = 32'h0;
    reg_err_i   = 1'b0;
    if (reg_we_o || reg_re_o) begin
      check("strobe_excl", {63'h0, reg_we_o & reg_re_o}, 64'h0);
      check("be_on", {60'h0, reg_be_o}, 64'hF);
      strobe_q.push_back({reg_we_o, reg_addr_o, reg_we_o ? reg_wdata_o : 32'h0});
    end
    if (reg_we_o && reg_addr_o == 8'h10 && reg_wdata_o[8]) busy_left = busy_cfg;
    if (reg_re_o && reg_addr_o == 8'h10) begin
      reg_rdata_i = (busy_inf || busy_left > 0) ? 32'h0000_2120 : 32'h0000_2020;
      if (busy_left > 0) busy_left--;
    end else if (reg_re_o && reg_addr_o == 8'h00) begin
      reg_rdata_i = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
    end
    if (err_arm && reg_we_o && reg_addr_o == 8'h00) begin
      reg_err_i = 1'b1;
      err_arm   = 1'b0;
    end
  endtask

  // polls < 0 means the core never clears busy; rnd_rdy randomises consumer backpressure.
  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int words,
                         input int polls, input bit err_tx, input int stall, input bit rnd_rdy);
    logic [40:0] exp_s[$];
    logic [32:0] exp_r[$];
    logic [32:0] held;
    bit          acc, seen;
    int          stall_left;
    logic [31:0] w;

    strobe_q.delete(); rsp_q.delete(); rx_q.delete();
    busy_cfg = polls; busy_inf = (polls < 0); busy_left = 0; err_arm = err_tx;

    exp_s.push_back(wr(8'h14, 32'h1));
    exp_s.push_back(wr(8'h18, 32'h1));
    exp_s.push_back(wr(8'h00, {cmd, addr}));
    if (err_tx) begin
      exp_s.push_back(wr(8'h18, 32'h0));
      exp_r.push_back({1'b1, 32'h0});
    end else if (busy_inf) begin
      exp_s.push_back(wr(8'h10, 32'h2120));
      for (int i = 0; i < 15; i++) exp_s.push_back(rd(8'h10));
      exp_s.push_back(wr(8'h18, 32'h0));
      exp_r.push_back({1'b1, 32'h0});
    end else begin
      exp_s.push_back(wr(8'h10, 32'h2120));
      for (int i = 0; i <= polls; i++) exp_s.push_back(rd(8'h10));
      for (int k = 0; k < words; k++) begin
        w = (rx_plan.size() > 0) ? rx_plan.pop_front() : $urandom;
        rx_q.push_back(w);
        exp_s.push_back(wr(8'h00, 32'h0));
        exp_s.push_back(wr(8'h10, 32'h2120));
        for (int i = 0; i <= polls; i++) exp_s.push_back(rd(8'h10));
        exp_s.push_back(rd(8'h00));
        exp_r.push_back({1'b0, w});
      end
      exp_s.push_back(wr(8'h18, 32'h0));
    end
    rx_plan.delete();

    req_cmd_i = cmd; req_addr_i = addr; req_words_i = words[7:0];
    req_valid_i = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = req_ready_o;
      cyc();
    end
    req_valid_i = 1'b0;
    check("accepted", {63'h0, acc}, 64'h1);
    check("busy_start", {63'h0, busy_o}, 64'h1);

    stall_left = stall;
    seen = 1'b0;
    held = 33'h0;
    for (int g = 0; g < 3000 && busy_o; g++) begin
      if (rsp_valid_o && stall_left > 0) begin
        if (!seen) begin
          seen = 1'b1;
          held = {rsp_err_o, rsp_data_o};
        end else begin
          check("stall_hold", {30'h0, rsp_valid_o, rsp_err_o, rsp_data_o}, {30'h0, 1'b1, held});
        end
        check("stall_quiet", {62'h0, reg_we_o, reg_re_o}, 64'h0);
        rsp_ready_i = 1'b0;
        stall_left--;
      end else begin
        rsp_ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      cyc();
    end
    rsp_ready_i = 1'b0;
    check("done_in_budget", {63'h0, busy_o}, 64'h0);
    check("ready_after", {63'h0, req_ready_o}, 64'h1);

    check("n_strobes", 64'(strobe_q.size()), 64'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < strobe_q.size(); i++)
      check($sformatf("strobe%0d", i), {23'h0, strobe_q[i]}, {23'h0, exp_s[i]});
    check("n_beats", 64'(rsp_q.size()), 64'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < rsp_q.size(); i++)
      check($sformatf("beat%0d", i), {31'h0, rsp_q[i]}, {31'h0, exp_r[i]});
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b1; req_cmd_i = 8'h0; req_addr_i = 24'h0; req_words_i = 8'h0;
    rsp_ready_i = 1'b0; reg_rdata_i = 32'h0; reg_err_i = 1'b0;
    busy_cfg = 0; busy_left = 0; busy_inf = 1'b0; err_arm = 1'b0;

    // reset with a request pending: everything quiet
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {54'h0, req_ready_o, rsp_valid_o, rsp_err_o, busy_o, reg_we_o, reg_re_o, reg_be_o},
          64'h0);
    check("rst_data", {rsp_data_o, reg_wdata_o}, 64'h0);
    check("rst_addr", {56'h0, reg_addr_o}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_first_edge", {62'h0, req_ready_o, busy_o}, 64'h2);
    req_valid_i = 1'b0;
    cyc();

    // two-word read with three busy polls per transfer
    rx_plan.push_back(32'hA5A5_A5A5);
    rx_plan.push_back(32'h5A5A_5A5A);
    run_txn(8'h03, 24'h00_1234, 2, 3, 1'b0, 0, 1'b0);

    // header only
    run_txn(8'h9F, 24'hAB_CDEF, 0, 1, 1'b0, 0, 1'b0);

    // consumer stalls 20 cycles on the first word
    run_txn(8'h0B, 24'h10_0000, 2, 0, 1'b0, 20, 1'b0);

    // busy never clears
    run_txn(8'h03, 24'h00_0040, 3, -1, 1'b0, 0, 1'b0);

    // access error on the header TX write, then a clean request
    run_txn(8'h03, 24'h00_0080, 2, 2, 1'b1, 0, 1'b0);
    run_txn(8'h03, 24'h00_00C0, 1, 2, 1'b0, 0, 1'b0);

    // randomised requests with random backpressure
    for (int n = 0; n < 8; n++)
      run_txn(8'($urandom), 24'($urandom), $urandom_range(0, 4), $urandom_range(0, 5),
              1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
